tone_sweep_ctrl: RTL and testbench
==================================

// Module: tone_sweep_ctrl
// PURPOSE
//  Sequences the dual-tone DDS test source into fixed-length frames for the FFT input.
//  Owns both phase accumulators and drives the dual-port cosine ROM addresses.
//  Sums the two ROM outputs, buffers samples in a small FIFO and presents them on a
//  valid/ready/last stream. After each frame, steps both tone frequencies for a sweep run.
// PARAMETERS
//  CNT_WIDTH    32         phase accumulator / frequency word width
//  FRAME_LEN    1024       samples per frame (>=2)
//  FREQ_START_I 128849019  tone I frequency word for step 0 (3 MHz)
//  FREQ_START_Q 300647711  tone Q frequency word for step 0 (7 MHz)
//  FREQ_STEP    4294967    added to both words after each frame, modulo 2^CNT_WIDTH
//  NUM_STEPS    16         frames per sweep run (>=1)
//  GAP_CYCLES   8          idle cycles between frames (>=0)
//  ROM_LAT      1          ROM read latency in cycles, address to data (>=1)
//  FIFO_DEPTH   4          output FIFO entries, power of 2, >= ROM_LAT+2
// PORTS
//  sclk        in   1          clock
//  rst         in   1          synchronous reset, active high
//  start       in   1          pulse: begin sweep (ignored unless IDLE)
//  stop        in   1          level/pulse: abort to IDLE
//  addr_I      out  10         ROM port A address = acc_I[CNT_WIDTH-1 -: 10]
//  addr_Q      out  10         ROM port B address = acc_Q[CNT_WIDTH-1 -: 10]
//  rom_I       in   14 signed  ROM port A data, ROM_LAT cycles after addr_I
//  rom_Q       in   14 signed  ROM port B data, ROM_LAT cycles after addr_Q
//  m_tdata     out  14 signed  summed sample
//  m_tvalid    out  1          sample valid
//  m_tready    in   1          consumer ready
//  m_tlast     out  1          last sample of frame
//  freq_I_out  out  CNT_WIDTH  current tone I frequency word
//  freq_Q_out  out  CNT_WIDTH  current tone Q frequency word
//  step_idx    out  8          current frame index within the sweep
//  busy        out  1          high in every state except IDLE
//  done        out  1          one-cycle pulse when the sweep completes
// BEHAVIOUR
//  Reset/IDLE: accumulators=0, addr_*=0, FIFO empty, m_tvalid=0, m_tlast=0, m_tdata=0,
//   busy=0, done=0, step_idx=0, freq_*_out=FREQ_START_*. rst clears in-flight tracking.
//  FSM states: IDLE, RUN, DRAIN, GAP, DONE.
//   IDLE->RUN on start, when stop=0. If start and stop are high together, stop wins.
//  RUN: issue a read on a cycle when (fifo_count + inflight) < FIFO_DEPTH.
//   On an issue cycle: addr_* = acc top bits; acc_* += freq_*; issue_cnt++.
//   Tag the sample last when issue_cnt == FRAME_LEN-1. After FRAME_LEN issues -> DRAIN.
//  Datapath: the ROM pair returned ROM_LAT cycles after an issue is registered once, as
//   sum = {rom_I[13],rom_I[13:1]} + {rom_Q[13],rom_Q[13:1]}. The sum is then pushed
//   with its last tag. inflight counts issues not yet pushed. It never exceeds ROM_LAT+1.
//  Latency: first m_tvalid occurs exactly ROM_LAT+2 cycles after the cycle start is sampled.
//  Stream: m_tvalid = FIFO not empty. Pop on m_tvalid && m_tready.
//   m_tdata and m_tlast stay stable while m_tvalid && !m_tready.
//   With m_tready held high, a frame is FRAME_LEN consecutive beats with no bubbles.
//  DRAIN: wait for inflight==0 and the FIFO to be empty (last beat accepted). Then:
//   if step_idx==NUM_STEPS-1 -> DONE; else step_idx++, freq_* += FREQ_STEP (wraps),
//   acc_*=0 (each frame starts at phase 0), issue_cnt=0 -> GAP.
//  GAP: count GAP_CYCLES cycles, then -> RUN. If GAP_CYCLES=0, go straight to RUN.
//  DONE: done=1 for one cycle; restore freq_* to FREQ_START_*; step_idx=0; -> IDLE.
//  stop (any non-IDLE state): next cycle IDLE with reset values. Flush FIFO, discard in-flight.
//   The frame is truncated and no m_tlast is emitted. This abort is intentional.
//  Push and pop in the same cycle: count unchanged. The credit rule means the FIFO never overflows.
//  Arithmetic: accumulator and frequency additions wrap modulo 2^CNT_WIDTH, with no saturation.
//   The halved sum cannot overflow 14 bits.
// TESTING
//  (Bench uses FRAME_LEN=16, NUM_STEPS=3, GAP_CYCLES=4, ROM_LAT=1; the ROM model is a behavioural cosine table.)
//  start pulse at cycle 0, m_tready=1 -> m_tvalid first high at cycle 3; 16 back-to-back beats;
//   m_tlast on beat 16 only; first addr_I of the frame = 0.
//  m_tready low for 20 cycles mid-frame -> m_tvalid held, m_tdata stable, issue stops at 4 buffered;
//   the beat sequence matches the reference model with no loss or duplicate.
//  Full sweep -> freq_I_out = 128849019, 133143986, 137438953 per frame; >=4 idle cycles between
//   m_tlast and the next m_tvalid; done pulses once after the third frame; then busy=0.
//  stop on beat 7 of frame 1 -> next cycle m_tvalid=0, busy=0, freq_I_out=FREQ_START_I;
//   a new start replays frame 0 exactly.
//  FREQ_START_I=32'hFFFF_FFF0, FREQ_STEP=32'h20 -> freq_I_out wraps to 32'h10 on step 1; no X.
//  start and stop in the same cycle -> stays IDLE. start while busy -> ignored, no restart.

Source files
------------

// File: rtl/tone_sweep_ctrl.sv
// rtl/tone_sweep_ctrl.sv - dual-tone DDS sweep sequencer with framed sample stream
module tone_sweep_ctrl #(
  parameter int                   CNT_WIDTH    = 32,
  parameter int                   FRAME_LEN    = 1024,
  parameter logic [CNT_WIDTH-1:0] FREQ_START_I = CNT_WIDTH'(128849019),
  parameter logic [CNT_WIDTH-1:0] FREQ_START_Q = CNT_WIDTH'(300647711),
  parameter logic [CNT_WIDTH-1:0] FREQ_STEP    = CNT_WIDTH'(4294967),
  parameter int                   NUM_STEPS    = 16,
  parameter int                   GAP_CYCLES   = 8,
  parameter int                   ROM_LAT      = 1,
  parameter int                   FIFO_DEPTH   = 4
) (
  input  logic                 sclk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  output logic [9:0]           addr_I,
  output logic [9:0]           addr_Q,
  input  logic signed [13:0]   rom_I,
  input  logic signed [13:0]   rom_Q,
  output logic signed [13:0]   m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 m_tlast,
  output logic [CNT_WIDTH-1:0] freq_I_out,
  output logic [CNT_WIDTH-1:0] freq_Q_out,
  output logic [7:0]           step_idx,
  output logic                 busy,
  output logic                 done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, GAP, DONE} state_t;

  // Port A carries tone I, port B carries tone Q.
  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   acc_a_q, acc_a_d, acc_b_q, acc_b_d;
  logic [CNT_WIDTH-1:0]   freq_a_q, freq_a_d, freq_b_q, freq_b_d;
  logic [31:0]            issue_cnt_q, issue_cnt_d, gap_cnt_q, gap_cnt_d;
  logic [7:0]             step_q, step_d;
  logic                   issue, issue_last, drain_ok;
  logic [CW:0]            credit;

  logic [ROM_LAT-1:0]     pipe_vld_q, pipe_last_q;
  logic                   sum_vld_q, sum_last_q;
  logic signed [13:0]     sum_q, half_a, half_b;
  logic [14:0]            mem_q [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          fifo_cnt_q, inflight_q;
  logic                   push, pop;
  logic                   unused_lsbs;

  assign addr_I      = acc_a_q[CNT_WIDTH-1 -: 10];
  assign addr_Q      = acc_b_q[CNT_WIDTH-1 -: 10];
  assign freq_I_out  = freq_a_q;
  assign freq_Q_out  = freq_b_q;
  assign step_idx    = step_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);

  assign half_a      = {rom_I[13], rom_I[13:1]};
  assign half_b      = {rom_Q[13], rom_Q[13:1]};
  assign unused_lsbs = rom_I[0] ^ rom_Q[0];

  assign m_tvalid    = (fifo_cnt_q != '0);
  assign m_tdata     = m_tvalid ? mem_q[rd_ptr_q][13:0] : 14'sd0;
  assign m_tlast     = m_tvalid && mem_q[rd_ptr_q][14];
  assign push        = sum_vld_q;
  assign pop         = m_tvalid && m_tready;

  // Sequencing: credit-gated ROM issue, frame drain, frequency stepping, abort on stop.
  always_comb begin
    state_d     = state_q;
    acc_a_d     = acc_a_q;
    acc_b_d     = acc_b_q;
    freq_a_d    = freq_a_q;
    freq_b_d    = freq_b_q;
    issue_cnt_d = issue_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    step_d      = step_q;
    issue       = 1'b0;
    issue_last  = 1'b0;
    credit      = {1'b0, fifo_cnt_q} + {1'b0, inflight_q};
    drain_ok    = (inflight_q == '0) && (fifo_cnt_q == '0);
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (credit < (CW+1)'(FIFO_DEPTH)) begin
          issue       = 1'b1;
          acc_a_d     = acc_a_q + freq_a_q;
          acc_b_d     = acc_b_q + freq_b_q;
          issue_cnt_d = issue_cnt_q + 32'd1;
          if (issue_cnt_q == 32'(FRAME_LEN-1)) begin
            issue_last = 1'b1;
            state_d    = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (drain_ok) begin
          acc_a_d     = '0;
          acc_b_d     = '0;
          issue_cnt_d = '0;
          gap_cnt_d   = '0;
          if (step_q == 8'(NUM_STEPS-1)) begin
            state_d = DONE;
          end else begin
            step_d   = step_q + 8'd1;
            freq_a_d = freq_a_q + FREQ_STEP;
            freq_b_d = freq_b_q + FREQ_STEP;
            state_d  = (GAP_CYCLES == 0) ? RUN : GAP;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == 32'(GAP_CYCLES-1)) state_d = RUN;
        else gap_cnt_d = gap_cnt_q + 32'd1;
      end
      DONE: begin
        freq_a_d = FREQ_START_I;
        freq_b_d = FREQ_START_Q;
        step_d   = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over everything, including a simultaneous start.
    if (stop) begin
      state_d     = IDLE;
      acc_a_d     = '0;
      acc_b_d     = '0;
      freq_a_d    = FREQ_START_I;
      freq_b_d    = FREQ_START_Q;
      step_d      = '0;
      issue_cnt_d = '0;
      gap_cnt_d   = '0;
      issue       = 1'b0;
      issue_last  = 1'b0;
    end
  end

  // Control state register.
  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_a_q     <= '0;
      acc_b_q     <= '0;
      freq_a_q    <= FREQ_START_I;
      freq_b_q    <= FREQ_START_Q;
      issue_cnt_q <= '0;
      gap_cnt_q   <= '0;
      step_q      <= '0;
    end else begin
      state_q     <= state_d;
      acc_a_q     <= acc_a_d;
      acc_b_q     <= acc_b_d;
      freq_a_q    <= freq_a_d;
      freq_b_q    <= freq_b_d;
      issue_cnt_q <= issue_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      step_q      <= step_d;
    end
  end

  // In-flight tracking, sum register and FIFO pointers; stop discards everything pending.
  always_ff @(posedge sclk) begin
    if (rst || stop) begin
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
      sum_vld_q   <= 1'b0;
      sum_last_q  <= 1'b0;
      sum_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      inflight_q  <= '0;
    end else begin
      pipe_vld_q[0]  <= issue;
      pipe_last_q[0] <= issue_last;
      for (int k = 1; k < ROM_LAT; k++) begin
        pipe_vld_q[k]  <= pipe_vld_q[k-1];
        pipe_last_q[k] <= pipe_last_q[k-1];
      end
      sum_vld_q  <= pipe_vld_q[ROM_LAT-1];
      sum_last_q <= pipe_last_q[ROM_LAT-1];
      if (pipe_vld_q[ROM_LAT-1]) sum_q <= half_a + half_b;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      fifo_cnt_q <= fifo_cnt_q + CW'(push) - CW'(pop);
      inflight_q <= inflight_q + CW'(issue) - CW'(push);
    end
  end

  // FIFO storage: {last, sample}.
  always_ff @(posedge sclk) begin
    if (push) mem_q[wr_ptr_q] <= {sum_last_q, sum_q};
  end

endmodule

// File: tb/tb_tone_sweep_ctrl.sv
// tb/tb_tone_sweep_ctrl.sv - directed vector bench for tone_sweep_ctrl
module tb_tone_sweep_ctrl;

  localparam int          FL   = 16;
  localparam logic [31:0] F0_I = 32'd128849019;
  localparam logic [31:0] F0_Q = 32'd300647711;

  logic sclk = 1'b0;
  always #5 sclk = ~sclk;

  logic               rst, start, stop, m_tready;
  logic [9:0]         addr_I, addr_Q;
  logic signed [13:0] rom_I, rom_Q, m_tdata;
  logic               m_tvalid, m_tlast, busy, done;
  logic [31:0]        freq_I_out, freq_Q_out;
  logic [7:0]         step_idx;

  logic               start_w, stop_w, m_tready_w;
  logic [9:0]         addr_I_w, addr_Q_w;
  logic signed [13:0] rom_I_w, rom_Q_w, m_tdata_w;
  logic               m_tvalid_w, m_tlast_w, busy_w, done_w;
  logic [31:0]        freq_I_w, freq_Q_w;
  logic [7:0]         step_idx_w;

  logic signed [13:0] tbl [1024];

  tone_sweep_ctrl #(.CNT_WIDTH(32), .FRAME_LEN(FL), .FREQ_START_I(F0_I), .FREQ_START_Q(F0_Q),
    .FREQ_STEP(32'd4294967), .NUM_STEPS(3), .GAP_CYCLES(4), .ROM_LAT(1), .FIFO_DEPTH(4)) dut (
    .sclk(sclk), .rst(rst), .start(start), .stop(stop), .addr_I(addr_I), .addr_Q(addr_Q),
    .rom_I(rom_I), .rom_Q(rom_Q), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .freq_I_out(freq_I_out), .freq_Q_out(freq_Q_out), .step_idx(step_idx),
    .busy(busy), .done(done));

  tone_sweep_ctrl #(.CNT_WIDTH(32), .FRAME_LEN(FL), .FREQ_START_I(32'hFFFF_FFF0), .FREQ_START_Q(F0_Q),
    .FREQ_STEP(32'h20), .NUM_STEPS(3), .GAP_CYCLES(4), .ROM_LAT(1), .FIFO_DEPTH(4)) dut_wrap (
    .sclk(sclk), .rst(rst), .start(start_w), .stop(stop_w), .addr_I(addr_I_w), .addr_Q(addr_Q_w),
    .rom_I(rom_I_w), .rom_Q(rom_Q_w), .m_tdata(m_tdata_w), .m_tvalid(m_tvalid_w), .m_tready(m_tready_w),
    .m_tlast(m_tlast_w), .freq_I_out(freq_I_w), .freq_Q_out(freq_Q_w), .step_idx(step_idx_w),
    .busy(busy_w), .done(done_w));

  // Behavioural cosine ROMs, one cycle read latency.
  always @(posedge sclk) begin
    rom_I   <= tbl[addr_I];
    rom_Q   <= tbl[addr_Q];
    rom_I_w <= tbl[addr_I_w];
    rom_Q_w <= tbl[addr_Q_w];
  end

  typedef struct {
    int          stall_at;
    int          restart_at;
    logic [31:0] fi;
    logic [31:0] fq;
    logic [7:0]  stp;
  } vec_t;
  vec_t vec [3];

  int                 total = 0, bad = 0, cyc = 0, done_cnt = 0, idle_run = 0, last_gap = 0;
  bit                 prev_valid = 1'b0;
  logic signed [13:0] cap_data [$];
  bit                 cap_last [$];
  int                 cap_cyc  [$];
  logic [31:0]        cap_fi   [$];
  logic [7:0]         cap_step [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic signed [13:0] model_beat(input logic [31:0] fi, input logic [31:0] fq, input int n);
    logic [31:0]        ai, aq;
    logic signed [13:0] hi, hq;
    ai = fi * 32'(n);
    aq = fq * 32'(n);
    hi = tbl[ai[31:22]] >>> 1;
    hq = tbl[aq[31:22]] >>> 1;
    return hi + hq;
  endfunction

  task automatic step();
    if (m_tvalid && m_tready) begin
      cap_data.push_back(m_tdata);
      cap_last.push_back(m_tlast);
      cap_cyc.push_back(cyc);
      cap_fi.push_back(freq_I_out);
      cap_step.push_back(step_idx);
    end
    @(posedge sclk);
    #1;
    cyc++;
    if (done) done_cnt++;
    if (m_tvalid && !prev_valid) last_gap = idle_run;
    if (m_tvalid) idle_run = 0;
    else idle_run++;
    prev_valid = m_tvalid;
  endtask

  task automatic do_stall(input string tag);
    logic signed [13:0] held;
    logic [9:0]         addr_mid;
    check($sformatf("%s_stall_entry_valid", tag), m_tvalid, 1);
    m_tready = 1'b0;
    held     = m_tdata;
    addr_mid = '0;
    for (int c = 1; c <= 20; c++) begin
      step();
      check($sformatf("%s_stall_valid%0d", tag, c), m_tvalid, 1);
      check($sformatf("%s_stall_data%0d", tag, c), m_tdata, held);
      if (c == 10) addr_mid = addr_I;
    end
    check($sformatf("%s_stall_issue_stopped", tag), addr_I, addr_mid);
    m_tready = 1'b1;
  endtask

  task automatic run_frame(input string tag, input logic [31:0] fi, input logic [31:0] fq,
                           input logic [7:0] stp, input int stall_at, input int restart_at, input int stop_at);
    int base, guard, k, expect_n;
    bit stalled, restarted;
    base      = cap_data.size();
    guard     = 0;
    stalled   = 1'b0;
    restarted = 1'b0;
    expect_n  = (stop_at >= 0) ? stop_at : FL;
    while ((cap_data.size() - base) < expect_n && guard < 600) begin
      k = cap_data.size() - base;
      if (k == stall_at && !stalled) begin
        do_stall(tag);
        stalled = 1'b1;
      end
      if (k == restart_at && !restarted) begin
        start     = 1'b1;
        restarted = 1'b1;
      end
      step();
      start = 1'b0;
      guard++;
    end
    check({tag, "_beats"}, cap_data.size() - base, expect_n);
    if (stop_at >= 0) begin
      check({tag, "_pre_stop_valid"}, m_tvalid, 1);
      stop     = 1'b1;
      m_tready = 1'b0;
      step();
      stop     = 1'b0;
      m_tready = 1'b1;
      check({tag, "_stop_valid"}, m_tvalid, 0);
      check({tag, "_stop_busy"}, busy, 0);
      check({tag, "_stop_last"}, m_tlast, 0);
      check({tag, "_stop_freq_i"}, freq_I_out, F0_I);
      check({tag, "_stop_step"}, step_idx, 0);
    end
    for (int n = 0; n < expect_n && (base + n) < cap_data.size(); n++) begin
      check($sformatf("%s_data%0d", tag, n), cap_data[base+n], model_beat(fi, fq, n));
      check($sformatf("%s_last%0d", tag, n), cap_last[base+n], (n == FL-1));
    end
    if (cap_data.size() > base) begin
      check({tag, "_freq_i"}, cap_fi[base], fi);
      check({tag, "_step_idx"}, cap_step[base], stp);
    end
    if (stall_at < 0 && stop_at < 0 && cap_data.size() >= base + FL)
      check({tag, "_no_bubble"}, cap_cyc[base+FL-1] - cap_cyc[base], FL-1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int       k, g;
    logic [9:0] a0, a1, q1;
    for (int i = 0; i < 1024; i++)
      tbl[i] = 14'($rtoi(8191.0 * $cos(2.0 * 3.14159265358979 * i / 1024.0)));

    vec[0] = '{stall_at: -1, restart_at: 3,  fi: F0_I,           fq: F0_Q,           stp: 8'd0};
    vec[1] = '{stall_at: 5,  restart_at: -1, fi: 32'd133143986,  fq: 32'd304942678,  stp: 8'd1};
    vec[2] = '{stall_at: -1, restart_at: -1, fi: 32'd137438953,  fq: 32'd309237645,  stp: 8'd2};

    rst = 1'b1; start = 1'b0; stop = 1'b0; m_tready = 1'b1;
    start_w = 1'b0; stop_w = 1'b0; m_tready_w = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_valid", m_tvalid, 0);
    check("rst_last", m_tlast, 0);
    check("rst_data", m_tdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_step", step_idx, 0);
    check("rst_freq_i", freq_I_out, F0_I);
    check("rst_freq_q", freq_Q_out, F0_Q);
    check("rst_addr_i", addr_I, 0);

    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check("start_stop_busy", busy, 0);
    step(); step();
    check("start_stop_busy_later", busy, 0);
    check("start_stop_valid", m_tvalid, 0);

    done_cnt = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("sweep_busy", busy, 1);
    a0 = addr_I;
    a1 = '0; q1 = '0;
    k  = 0;
    while (!m_tvalid && k < 20) begin
      step();
      k++;
      if (k == 1) begin
        a1 = addr_I;
        q1 = addr_Q;
      end
    end
    check("first_valid_latency", k, 3);
    check("first_addr_i", a0, 0);
    check("second_addr_i", a1, 30);
    check("second_addr_q", q1, 71);

    for (int f = 0; f < 3; f++) begin
      run_frame($sformatf("sweep_f%0d", f), vec[f].fi, vec[f].fq, vec[f].stp, vec[f].stall_at, vec[f].restart_at, -1);
      if (f > 0) check($sformatf("sweep_gap_f%0d", f), (last_gap >= 4), 1);
    end
    g = 0;
    while (busy && g < 100) begin
      step();
      g++;
    end
    check("sweep_done_pulses", done_cnt, 1);
    check("sweep_end_busy", busy, 0);
    check("sweep_end_valid", m_tvalid, 0);
    check("sweep_end_freq_i", freq_I_out, F0_I);
    check("sweep_end_step", step_idx, 0);

    start = 1'b1;
    step();
    start = 1'b0;
    run_frame("abort_f0", vec[0].fi, vec[0].fq, vec[0].stp, -1, -1, -1);
    run_frame("abort_f1", vec[1].fi, vec[1].fq, vec[1].stp, -1, -1, 6);
    start = 1'b1;
    step();
    start = 1'b0;
    run_frame("replay_f0", vec[0].fi, vec[0].fq, vec[0].stp, -1, -1, -1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("replay_abort_busy", busy, 0);

    check("wrap_freq_i_step0", freq_I_w, 32'hFFFF_FFF0);
    start_w = 1'b1;
    step();
    start_w = 1'b0;
    g = 0;
    while (step_idx_w != 8'd1 && g < 300) begin
      step();
      g++;
    end
    check("wrap_step_idx", step_idx_w, 1);
    check("wrap_freq_i_step1", freq_I_w, 32'h10);
    check("wrap_freq_q_step1", freq_Q_w, 32'd300647743);
    g = 0;
    while (busy_w && g < 300) begin
      step();
      g++;
    end
    check("wrap_end_busy", busy_w, 0);
    check("wrap_end_freq_i", freq_I_w, 32'hFFFF_FFF0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
